// File: rtl/signmag_pkg.sv
// Shared definitions for the sign-magnitude table writer: default operand
// width and the sweep controller state encoding.
package signmag_pkg;

  localparam int OP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/signmag_add.sv
// Combinational sign-magnitude adder. Magnitude overflow saturates to the
// all-ones magnitude with the common sign kept; any zero result is emitted
// as positive zero, so -0 never leaves this block.
module signmag_add
  import signmag_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] sum
);

  localparam int MAG_W = OP_W - 1;

  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;
  logic             sgn_a;
  logic             sgn_b;
  logic [MAG_W:0]   mag_add;
  logic [MAG_W-1:0] mag_res;
  logic             sgn_res;

  assign mag_a = a[MAG_W-1:0];
  assign mag_b = b[MAG_W-1:0];
  assign sgn_a = a[OP_W-1];
  assign sgn_b = b[OP_W-1];

  // Pick add or subtract by sign agreement, then normalise zero to +0.
  always_comb begin
    mag_add = {1'b0, mag_a} + {1'b0, mag_b};
    sgn_res = sgn_a;
    mag_res = '0;
    if (sgn_a == sgn_b) begin
      mag_res = mag_add[MAG_W] ? '1 : mag_add[MAG_W-1:0];
    end else if (mag_a >= mag_b) begin
      mag_res = mag_a - mag_b;
    end else begin
      sgn_res = sgn_b;
      mag_res = mag_b - mag_a;
    end
    if (mag_res == '0) begin
      sgn_res = 1'b0;
    end
    sum = {sgn_res, mag_res};
  end

endmodule

// File: rtl/signmag_table_writer.sv
// Sweeps every {a, b} operand pair once per start request and streams the
// sign-magnitude sum of each pair out as a write, honouring ready
// back-pressure. Address counter and FSM live here; the arithmetic is in
// signmag_add. Outputs are all registered; the adder is fed the next address
// so wr_data lines up with wr_addr in the same cycle.
module signmag_table_writer
  import signmag_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                ready,
  output logic                wr_en,
  output logic [2*OP_W-1:0]   wr_addr,
  output logic [OP_W-1:0]     wr_data,
  output logic                busy,
  output logic                done
);

  localparam int ADDR_W = 2 * OP_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OP_W-1:0]   data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [OP_W-1:0]   sum_next;

  signmag_add #(.OP_W(OP_W)) u_add (
    .a   (addr_d[ADDR_W-1:OP_W]),
    .b   (addr_d[OP_W-1:0]),
    .sum (sum_next)
  );

  // Next-state and next-output decode; a presented write only moves on
  // when ready accepts it, so stalls hold address and data.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en_d = wr_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (ready) begin
          if (addr_q == '1) begin
            state_d = ST_DONE;
            addr_d  = '0;
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    data_d = (state_d == ST_WRITE) ? sum_next : '0;
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_signmag_table_writer.sv
// Bench for signmag_table_writer at OP_W=8: full sweep into a memory model,
// back-pressure hold, mid-sweep reset and ignored start pulses.
module tb_signmag_table_writer;

  localparam int OP_W   = 8;
  localparam int ADDR_W = 16;
  localparam int N      = 1 << ADDR_W;
  localparam int MW     = OP_W - 1;
  localparam int MAXM   = (1 << MW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OP_W-1:0]   wr_data;
  logic              busy;
  logic              done;

  signmag_table_writer #(.OP_W(OP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ready   (ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_addr;
  int writes;
  int edges;
  int guard;
  logic [OP_W-1:0] mem [N];
  logic [OP_W-1:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: convert both operands to integers, add, clamp, re-encode.
  function automatic logic [OP_W-1:0] ref_sum(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int va, vb, s;
    logic [MW-1:0] m;
    va = a[OP_W-1] ? -int'(a[MW-1:0]) : int'(a[MW-1:0]);
    vb = b[OP_W-1] ? -int'(b[MW-1:0]) : int'(b[MW-1:0]);
    s  = va + vb;
    if (s > MAXM)  s = MAXM;
    if (s < -MAXM) s = -MAXM;
    m = MW'((s < 0) ? -s : s);
    return {(s < 0), m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the currently presented write, record it if this edge accepts it.
  task automatic step(input logic rdy, input logic st);
    ready = rdy;
    start = st;
    if (wr_en) begin
      chk("addr_order", 32'(wr_addr), 32'(exp_addr[ADDR_W-1:0]));
      chk("data", 32'(wr_data), 32'(ref_sum(wr_addr[ADDR_W-1:OP_W], wr_addr[OP_W-1:0])));
      chk("busy_in_sweep", 32'(busy), 32'd1);
      chk("done_in_sweep", 32'(done), 32'd0);
      if (rdy) begin
        mem[wr_addr] = wr_data;
        exp_addr++;
        writes++;
      end
    end else begin
      chk("wr_en_in_sweep", 32'(wr_en), 32'd1);
    end
    tick();
    edges++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    chk_idle("reset");
    chk("reset_done", 32'(done), 32'd0);
    repeat (3) tick();
    chk_idle("idle_hold");

    // Full sweep, ready high, random start pulses that must be ignored.
    exp_addr = 0;
    writes   = 0;
    start    = 1'b1;
    tick();
    edges = 0;
    chk("start_wr_en", 32'(wr_en), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    guard = 0;
    while (!done && guard < N + 16) begin
      step(1'b1, ($urandom_range(0, 7) == 0));
      guard++;
    end
    chk("sweep_done", 32'(done), 32'd1);
    chk("done_latency", 32'(edges), 32'(N));
    chk("sweep_writes", 32'(writes), 32'(N));
    chk_idle("done_state");
    start = 1'b1;
    ready = 1'b1;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk_idle("after_done");
    start = 1'b0;
    tick();
    chk_idle("no_second_sweep");
    chk("no_second_done", 32'(done), 32'd0);

    for (int i = 0; i < N; i++)
      chk("mem_word", 32'(mem[i]), 32'(ref_sum(i[15:8], i[7:0])));
    chk("spot_0503", 32'(mem[16'h0503]), 32'h08);
    chk("spot_8503", 32'(mem[16'h8503]), 32'h82);
    chk("spot_0383", 32'(mem[16'h0383]), 32'h00);
    chk("spot_7f01", 32'(mem[16'h7F01]), 32'h7F);
    chk("spot_ff81", 32'(mem[16'hFF81]), 32'hFF);

    // Back-pressure at 0x0010.
    exp_addr = 0;
    start    = 1'b1;
    tick();
    guard = 0;
    while (exp_addr != 16'h0010 && guard < 64) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("bp_reach", 32'(wr_addr), 32'h0010);
    held  = wr_data;
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_wr_en", 32'(wr_en), 32'd1);
      chk("bp_addr", 32'(wr_addr), 32'h0010);
      chk("bp_data", 32'(wr_data), 32'(held));
    end
    ready = 1'b1;
    tick();
    exp_addr = 16'h0011;
    chk("bp_advance", 32'(wr_addr), 32'h0011);
    chk("bp_adv_data", 32'(wr_data), 32'(ref_sum(8'h00, 8'h11)));

    // Random ready up to 0x1234, then reset mid-sweep.
    guard = 0;
    while (!(wr_en && wr_addr == 16'h1234) && guard < 40000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rst_reach", 32'(wr_addr), 32'h1234);
    reset = 1'b1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_idle("mid_reset");
    chk("mid_reset_done", 32'(done), 32'd0);
    tick();
    chk_idle("post_reset_idle");
    exp_addr = 0;
    start    = 1'b1;
    tick();
    chk("restart_wr_en", 32'(wr_en), 32'd1);
    chk("restart_addr", 32'(wr_addr), 32'h0000);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    chk("restart_progress", 32'(wr_addr), 32'h0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
